en_reg_led_bank: RTL
====================

// Module: en_reg_led_bank
// PURPOSE
//  WIDTH-bit load-enabled register bank; every bit drives an indicator LED output.
//  Runtime mode selects what the LEDs show: the bit value, a stretched activity pulse,
//  a blinking "bit set" indication, or nothing.
//  Used as a status/debug register on boards built from merged 74LVC cells.
// PARAMETERS
//  WIDTH           8    number of register bits / LED channels (>=1)
//  RESET_VALUE     '0   WIDTH-bit value loaded into q_o on reset
//  STRETCH_CYCLES  4    activity pulse length in clk_i cycles (>=1)
//  BLINK_DIV       8    blink half-period in clk_i cycles (>=1)
// PORTS
//  clk_i   in   1      single clock, all state updates on the rising edge
//  rst_ni  in   1      reset, synchronous, active-low
//  en_i    in   1      load enable: q_o <= d_i when high
//  d_i     in   WIDTH  load data
//  mode_i  in   2      LED mode: 00 DIRECT, 01 STRETCH, 10 BLINK, 11 OFF
//  q_o     out  WIDTH  register contents
//  led_o   out  WIDTH  per-bit LED drive, active-high
// BEHAVIOUR
//  - Reset is synchronous, active-low, and has priority over en_i.
//    At the reset edge: q_o <= RESET_VALUE, all stretch counters <= 0, prescaler <= 0,
//    blink_phase <= 0. Reset asserted mid-pulse or mid-blink clears that state at once.
//  - Register: en_i=1 -> q_o <= d_i (1-cycle latency); en_i=0 -> hold.
//  - Stretch counter per bit, width $clog2(STRETCH_CYCLES+1):
//    change[i] = en_i & (d_i[i] != q_o[i]).
//    On change[i]: cnt[i] <= STRETCH_CYCLES (also reloads while active).
//    Otherwise: if cnt[i] != 0 then cnt[i] <= cnt[i]-1.
//    A load that does not change the bit causes no trigger.
//  - Blink prescaler counts 0..BLINK_DIV-1, free-running.
//    At BLINK_DIV-1: prescaler <= 0 and blink_phase toggles.
//    So blink_phase changes every BLINK_DIV cycles and first goes high BLINK_DIV cycles
//    after reset is released.
//  - Counters and prescaler run in all modes. A mode change clears no state.
//  - led_o is combinational from registered state and mode_i; a mode change takes effect
//    in the same cycle:
//      DIRECT  : led_o[i] = q_o[i]
//      STRETCH : led_o[i] = (cnt[i] != 0)
//      BLINK   : led_o[i] = q_o[i] & blink_phase
//      OFF     : led_o[i] = 0
//  - Outputs during/after reset: q_o = RESET_VALUE; led_o = RESET_VALUE in DIRECT, 0 in the
//    other modes.
//  - mode_i is assumed stable or synchronous to clk_i. No X propagation from unused modes.
// STRUCTURE
//  - Package en_reg_led_pkg holds:
//    - led_mode_e enum {LED_DIRECT=2'b00, LED_STRETCH=2'b01, LED_BLINK=2'b10, LED_OFF=2'b11}
//    - the localparam function for the stretch counter width.
//  - Sub-module led_stretch_chan, instantiated WIDTH times in a generate loop.
//    - Inputs: clk_i, rst_ni, trig_i.
//    - Output: active_o.
//    - Contains one stretch counter.
//  - Shared in the top level: the q register, the blink prescaler, blink_phase and the
//    mode output mux.
// TESTING  (WIDTH=8, RESET_VALUE=8'h00, STRETCH_CYCLES=4, BLINK_DIV=8)
//  1. Reset priority: rst_ni=0 for 2 cycles with en_i=1, d_i=FF
//     -> q_o=00; led_o=00 in all four modes.
//  2. Load/hold: en_i=1, d_i=A5 for 1 cycle, then en_i=0, d_i=FF
//     -> q_o=A5 from the next cycle and held; DIRECT led_o=A5.
//  3. Stretch: q=00, load 01 -> STRETCH led_o[0]=1 for exactly 4 cycles.
//     Reload 01 -> no retrigger. Load 00 at the 2nd pulse cycle -> pulse extended to 4
//     cycles from that edge.
//  4. Blink: load FF, BLINK mode -> led_o=00 for cycles 0-7 after reset release, then
//     alternates FF/00 every 8 cycles. Bits with q=0 stay dark.
//  5. Mode switch: during a stretch pulse switch to OFF -> led_o=00 while the counter keeps
//     running. Switch back to STRETCH before expiry -> the remaining pulse is visible in the
//     same cycle.
//  6. Reset mid-operation: rst_ni=0 for 1 cycle during an active stretch and blink_phase=1
//     -> next cycle cnt=0, led_o=00 in STRETCH and BLINK, and the blink restarts its
//     8-cycle count.

Source files
------------

// File: rtl/en_reg_led_pkg.sv
// Shared types and sizing helpers for the LED register bank.
// Holds the LED mode encoding and the stretch counter width function.
package en_reg_led_pkg;

   typedef enum logic [1:0] {
      LED_DIRECT  = 2'b00,
      LED_STRETCH = 2'b01,
      LED_BLINK   = 2'b10,
      LED_OFF     = 2'b11
   } led_mode_e;

   // Counter must hold the value STRETCH_CYCLES itself, hence the +1.
   function automatic int stretch_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/en_reg_led_stretch_chan.sv
// One activity-stretch channel: a trigger loads the counter, which then counts down to zero.
// active_o is high while the counter is non-zero.
module led_stretch_chan
   import en_reg_led_pkg::*;
#(
   parameter int STRETCH_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic trig_i,
   output logic active_o
);

   localparam int CW = stretch_cnt_w(STRETCH_CYCLES);
   localparam logic [CW-1:0] LOAD_VAL = CW'(STRETCH_CYCLES);

   logic [CW-1:0] cnt;

   // NOTE: reset is sampled on the clock edge (synchronous), so it is not in the sensitivity list.
   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else if (trig_i) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign active_o = (cnt != '0);

endmodule

// File: rtl/en_reg_led_bank.sv
// Load-enabled status register whose bits each drive an LED, with a runtime-selectable
// display mode: direct value, stretched activity pulse, blinking "set" indication or off.
module en_reg_led_bank
   import en_reg_led_pkg::*;
#(
   parameter int               WIDTH          = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
   parameter int               STRETCH_CYCLES = 4,
   parameter int               BLINK_DIV      = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] led_o
);

   localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);

   logic [WIDTH-1:0] change;
   logic [WIDTH-1:0] active;
   logic [PW-1:0]    prescaler;
   logic             blink_phase;
   led_mode_e        mode;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         q_o <= RESET_VALUE;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

   // Only a load that actually flips a bit counts as activity.
   assign change = {WIDTH{en_i}} & (d_i ^ q_o);

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      led_stretch_chan #(
         .STRETCH_CYCLES(STRETCH_CYCLES)
      ) u_chan (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .trig_i  (change[i]),
         .active_o(active[i])
      );
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prescaler   <= '0;
         blink_phase <= 1'b0;
      end else if (prescaler == PRESC_MAX) begin
         prescaler   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   assign mode = led_mode_e'(mode_i);

   // NOTE: led_o gets a default before the case so no path can infer a latch.
   always_comb begin
      led_o = '0;
      case (mode)
         LED_DIRECT:  led_o = q_o;
         LED_STRETCH: led_o = active;
         LED_BLINK:   led_o = q_o & {WIDTH{blink_phase}};
         LED_OFF:     led_o = '0;
         default:     led_o = '0;
      endcase
   end

endmodule
